// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, single-outstanding imem requests, skid-buffered output to decode
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [15:0] W_STEP = 16'(PC_STEP);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pc;
    logic [15:0] r_req_pc;
    logic        r_out_valid;
    logic [15:0] r_out_instr;
    logic [15:0] r_out_pc;
    logic        r_skid_valid;
    logic [15:0] r_skid_instr;
    logic [15:0] r_skid_pc;

    logic        w_issue;
    logic        w_consume;
    logic        w_resp_keep;
    logic [15:0] w_redirect_target;

    // Bit 0 of the redirect target is forced low so the PC stays halfword aligned.
    assign w_redirect_target = redirect_pc & 16'hFFFE;
    assign w_issue     = !rst && (r_state == IDLE) && !r_skid_valid && !redirect_valid;
    assign w_consume   = r_out_valid && if_ready;
    assign w_resp_keep = (r_state == WAIT) && imem_rvalid && !redirect_valid;

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;
    assign if_valid  = r_out_valid;
    assign if_instr  = r_out_instr;
    assign if_pc     = r_out_pc;

    // State register for the request tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: a redirect turns a kept response into a dropped one; any response frees the slot.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_state_next = IDLE;
                end else if (redirect_valid) begin
                    w_state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // PC update: redirect has priority over sequential advance; req_pc tags the outstanding fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= 16'h0000;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (w_issue) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + W_STEP;
        end
    end

    // Output register and one-entry skid buffer; skid only fills while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= 16'h0000;
            r_out_pc     <= 16'h0000;
            r_skid_valid <= 1'b0;
            r_skid_instr <= 16'h0000;
            r_skid_pc    <= 16'h0000;
        end else if (redirect_valid) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_resp_keep) begin
            if (!r_out_valid || w_consume) begin
                r_out_valid <= 1'b1;
                r_out_instr <= imem_rdata;
                r_out_pc    <= r_req_pc;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_req_pc;
            end
        end else if (w_consume) begin
            if (r_skid_valid) begin
                r_out_instr  <= r_skid_instr;
                r_out_pc     <= r_skid_pc;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed table-driven bench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;

    logic        d2_req;
    logic [15:0] d2_addr;
    logic        d2_valid;
    logic [15:0] d2_instr;
    logic [15:0] d2_pc;

    int errors = 0;
    int checks = 0;

    // memory model state
    int          lat = 1;
    logic        m_pend = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_addr = 16'h0000;

    logic [15:0] d2_log[$];

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
    } vec_t;

    vec_t tbl[19];

    instr_fetch #(.RESET_PC(16'h0000), .PC_STEP(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    instr_fetch #(.RESET_PC(16'hFFFC), .PC_STEP(2)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(d2_req), .imem_addr(d2_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(d2_valid), .if_ready(if_ready),
        .if_instr(d2_instr), .if_pc(d2_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] a);
        return {a[7:0] + 8'h02, a[7:0] + 8'h01};
    endfunction

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [15:0] rpc,
                                input logic er, input logic [15:0] ea, input logic ev,
                                input logic [15:0] ei, input logic [15:0] ep);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: capture the request, cross the edge, then update the memory response.
    task automatic step();
        logic        req_seen;
        logic [15:0] req_addr;
        req_seen = imem_req;
        req_addr = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (m_pend) begin
            m_cnt--;
            if (m_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word(m_addr);
                m_pend      = 1'b0;
            end
        end
        if (req_seen === 1'b1) begin
            m_pend = 1'b1;
            m_addr = req_addr;
            m_cnt  = lat - 1;
            if (m_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word(m_addr);
                m_pend      = 1'b0;
            end
        end
    endtask

    initial begin
        logic found;
        clk = 1'b0;
        rst = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 16'h0000;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        if_ready = 1'b1;

        //           rst rdy rv rpc       req addr      v  instr     pc
        tbl[0]  = mk(1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        tbl[1]  = mk(0, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000);
        tbl[2]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        tbl[3]  = mk(0, 0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0201, 16'h0000);
        tbl[4]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0201, 16'h0000);
        tbl[5]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0201, 16'h0000);
        tbl[6]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0201, 16'h0000);
        tbl[7]  = mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0201, 16'h0000);
        tbl[8]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0201, 16'h0000);
        tbl[9]  = mk(0, 1, 0, 16'h0000, 1, 16'h0004, 1, 16'h0403, 16'h0002);
        tbl[10] = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        tbl[11] = mk(0, 1, 0, 16'h0000, 1, 16'h0006, 1, 16'h0605, 16'h0004);
        tbl[12] = mk(0, 1, 1, 16'h0041, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        tbl[13] = mk(0, 1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000);
        tbl[14] = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        tbl[15] = mk(0, 1, 0, 16'h0000, 1, 16'h0042, 1, 16'h4241, 16'h0040);
        tbl[16] = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        tbl[17] = mk(0, 1, 1, 16'h0081, 0, 16'h0000, 1, 16'h4443, 16'h0042);
        tbl[18] = mk(0, 1, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000, 16'h0000);

        step();
        step();

        for (int i = 0; i < 19; i++) begin
            rst            = tbl[i].rst;
            if_ready       = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            #1;
            chk($sformatf("row%0d imem_req", i), {15'd0, imem_req}, {15'd0, tbl[i].e_req});
            if (tbl[i].e_req)
                chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("row%0d if_valid", i), {15'd0, if_valid}, {15'd0, tbl[i].e_valid});
            if (tbl[i].e_valid || tbl[i].rst) begin
                chk($sformatf("row%0d if_instr", i), if_instr, tbl[i].e_instr);
                chk($sformatf("row%0d if_pc", i), if_pc, tbl[i].e_pc);
            end
            chk($sformatf("row%0d wrap imem_req", i), {15'd0, d2_req}, {15'd0, tbl[i].e_req});
            if (d2_req === 1'b1) d2_log.push_back(d2_addr);
            if (i == 3) chk("wrap if_pc first", d2_pc, 16'hFFFC);
            step();
        end
        redirect_valid = 1'b0;

        chk("wrap request count", 16'(d2_log.size() >= 3), 16'd1);
        if (d2_log.size() >= 3) begin
            chk("wrap addr0", d2_log[0], 16'hFFFC);
            chk("wrap addr1", d2_log[1], 16'hFFFE);
            chk("wrap addr2", d2_log[2], 16'h0000);
        end

        // Redirect while a 3-cycle request is outstanding: its word must be dropped.
        rst = 1'b1;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b0;
        lat = 3;
        #1; chk("drop a1 req", {15'd0, imem_req}, 16'd1);
        chk("drop a1 addr", imem_addr, 16'h0000);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0041;
        #1; chk("drop a2 req", {15'd0, imem_req}, 16'd0);
        step();
        redirect_valid = 1'b0;
        #1; chk("drop a3 req", {15'd0, imem_req}, 16'd0);
        step();
        #1; chk("drop a4 req", {15'd0, imem_req}, 16'd0);
        chk("drop a4 valid", {15'd0, if_valid}, 16'd0);
        step();
        #1; chk("drop a5 valid", {15'd0, if_valid}, 16'd0);
        chk("drop a5 req", {15'd0, imem_req}, 16'd1);
        chk("drop a5 addr", imem_addr, 16'h0040);
        step();
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            #1;
            if (if_valid === 1'b1) found = 1'b1;
            else step();
        end
        chk("drop deliver seen", {15'd0, found}, 16'd1);
        chk("drop deliver pc", if_pc, 16'h0040);
        chk("drop deliver instr", if_instr, 16'h4241);
        step();

        // Reset mid-WAIT with a 3-cycle memory; the late response must be ignored.
        rst = 1'b1;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b0;
        #1; chk("rstw b1 req", {15'd0, imem_req}, 16'd1);
        chk("rstw b1 addr", imem_addr, 16'h0000);
        step();
        #1; chk("rstw b2 req", {15'd0, imem_req}, 16'd0);
        step();
        rst = 1'b1;
        #1; step();
        rst = 1'b0;
        #1; chk("rstw b4 valid", {15'd0, if_valid}, 16'd0);
        chk("rstw b4 instr", if_instr, 16'h0000);
        chk("rstw b4 pc", if_pc, 16'h0000);
        chk("rstw b4 req", {15'd0, imem_req}, 16'd1);
        chk("rstw b4 addr", imem_addr, 16'h0000);
        step();
        for (int k = 5; k <= 7; k++) begin
            #1; chk($sformatf("rstw b%0d valid", k), {15'd0, if_valid}, 16'd0);
            step();
        end
        #1; chk("rstw b8 valid", {15'd0, if_valid}, 16'd1);
        chk("rstw b8 instr", if_instr, 16'h0201);
        chk("rstw b8 pc", if_pc, 16'h0000);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
